// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and constants for the two-master Wishbone arbiter.
//   arb_state_e    - arbiter FSM state (IDLE, GNT0, GNT1, DRAIN)
//   M_CPU / M_EXT  - master indices (M0 = CPU data master, M1 = external engine)
//   wd_cnt_width() - width of the watchdog counter for a given cycle limit
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_EXT = 1'b1;

    function automatic int wd_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if: Wishbone classic signal bundle around the arbiter.
//   m0_* / m1_*  master request (cyc/stb/we/adr/dat/sel in, ack/err out)
//   m_dat_o      read data broadcast to both masters
//   s_*          shared slave bus (request out, dat/ack/err in)
// Modports:
//   slave  - the arbiter's view (slave to the masters, owner of the slave bus)
//   master - the environment's view (masters plus the slave device)
interface wb_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    logic                  m0_cyc_i, m0_stb_i, m0_we_i;
    logic [ADDR_WIDTH-1:0] m0_adr_i;
    logic [DATA_WIDTH-1:0] m0_dat_i;
    logic [SEL_WIDTH-1:0]  m0_sel_i;
    logic                  m0_ack_o, m0_err_o;

    logic                  m1_cyc_i, m1_stb_i, m1_we_i;
    logic [ADDR_WIDTH-1:0] m1_adr_i;
    logic [DATA_WIDTH-1:0] m1_dat_i;
    logic [SEL_WIDTH-1:0]  m1_sel_i;
    logic                  m1_ack_o, m1_err_o;

    logic [DATA_WIDTH-1:0] m_dat_o;

    logic                  s_cyc_o, s_stb_o, s_we_o;
    logic [ADDR_WIDTH-1:0] s_adr_o;
    logic [DATA_WIDTH-1:0] s_dat_o;
    logic [SEL_WIDTH-1:0]  s_sel_o;
    logic [DATA_WIDTH-1:0] s_dat_i;
    logic                  s_ack_i, s_err_i;

    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        output m0_ack_o, m0_err_o,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        output m1_ack_o, m1_err_o,
        output m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        input  m0_ack_o, m0_err_o,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        input  m1_ack_o, m1_err_o,
        input  m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_dat_i, s_ack_i, s_err_i
    );

endinterface

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: stall counter for the arbiter's slave-access timeout.
//   clk_i, rst_i - clock, synchronous active-high reset
//   clr_i        - clear the count (new grant or slave termination)
//   inc_i        - count one stalled strobe cycle
//   expire_o     - count has reached TIMEOUT_CYCLES
// Only instantiated when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);
    import wb_arb_pkg::*;

    localparam int                CNT_W = wd_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT)) begin
            // saturate so a stuck count can never wrap back below the limit
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master Wishbone classic arbiter, round-robin at cycle
// boundaries, with an ext_only_i lock that restricts grants to M1.
//   clk_i, rst_i  - clock, synchronous active-high reset
//   ext_only_i    - when high, only M1 may win a new grant
//   grant_o       - registered one-hot grant ({M1, M0})
//   bus           - wb_bus_arbiter_if.slave: both masters and the slave bus
// Optional feature macro: WB_ARB_TIMEOUT_EN (slave watchdog + DRAIN state).
module wb_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ext_only_i,
    output logic [1:0]       grant_o,
    wb_bus_arbiter_if.slave  bus
);
    import wb_arb_pkg::*;

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;

    logic req0, req1, in_gnt, sel_m1, drive, expire;

    assign req0   = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1   = bus.m1_cyc_i & bus.m1_stb_i;
    assign in_gnt = (state_q == GNT0) || (state_q == GNT1);
    assign sel_m1 = (state_q == GNT1);
    // On the expiry cycle the slave is not strobed; only the err pulse goes out.
    assign drive  = in_gnt & ~expire;

    logic                  cyc_mux, stb_mux, we_mux;
    logic [ADDR_WIDTH-1:0] adr_mux;
    logic [DATA_WIDTH-1:0] dat_mux;
    logic [SEL_WIDTH-1:0]  sel_mux;

`ifdef WB_ARB_TIMEOUT_EN
    logic wd_clr, wd_inc, wd_expire;

    // Outside a grant the count is held at zero, so every grant starts fresh.
    assign wd_clr = ~in_gnt | bus.s_ack_i | bus.s_err_i;
    assign wd_inc = stb_mux & ~bus.s_ack_i & ~bus.s_err_i;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (wd_clr),
        .inc_i   (wd_inc),
        .expire_o(wd_expire)
    );

    assign expire = in_gnt & wd_expire;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES != 0);
    assign expire     = 1'b0;
`endif

    // Next-state and round-robin bookkeeping.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (ext_only_i) begin
                    if (req1) state_d = GNT1;
                end else if (req0 && req1) begin
                    state_d = (last_q == M_CPU) ? GNT1 : GNT0;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (expire) begin
                    state_d = DRAIN;
                end else if (!bus.m0_cyc_i) begin
                    state_d = IDLE;
                    last_d  = M_CPU;
                end
            end
            GNT1: begin
                if (expire) begin
                    state_d = DRAIN;
                end else if (!bus.m1_cyc_i) begin
                    state_d = IDLE;
                    last_d  = M_EXT;
                end
            end
            DRAIN: begin
                // grant_q still names the master whose access timed out
                if (!(grant_q[M_EXT] ? bus.m1_cyc_i : bus.m0_cyc_i)) begin
                    state_d = IDLE;
                    last_d  = grant_q[M_EXT];
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            GNT0:    grant_d = 2'b01;
            GNT1:    grant_d = 2'b10;
            DRAIN:   grant_d = grant_q;
            default: grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= M_EXT;   // so M0 wins the first tie after reset
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Slave-side request mux; everything reads zero when nobody owns the bus.
    always_comb begin
        cyc_mux = 1'b0;
        stb_mux = 1'b0;
        we_mux  = 1'b0;
        adr_mux = '0;
        dat_mux = '0;
        sel_mux = '0;
        if (drive) begin
            if (sel_m1) begin
                cyc_mux = bus.m1_cyc_i;
                stb_mux = bus.m1_stb_i;
                we_mux  = bus.m1_we_i;
                adr_mux = bus.m1_adr_i;
                dat_mux = bus.m1_dat_i;
                sel_mux = bus.m1_sel_i;
            end else begin
                cyc_mux = bus.m0_cyc_i;
                stb_mux = bus.m0_stb_i;
                we_mux  = bus.m0_we_i;
                adr_mux = bus.m0_adr_i;
                dat_mux = bus.m0_dat_i;
                sel_mux = bus.m0_sel_i;
            end
        end
    end

    assign bus.s_cyc_o = cyc_mux;
    assign bus.s_stb_o = stb_mux;
    assign bus.s_we_o  = we_mux;
    assign bus.s_adr_o = adr_mux;
    assign bus.s_dat_o = dat_mux;
    assign bus.s_sel_o = sel_mux;

    // Terminations pass straight through to the owner; idle/DRAIN acks are dropped.
    assign bus.m0_ack_o = (state_q == GNT0) & ~expire & bus.s_ack_i;
    assign bus.m1_ack_o = (state_q == GNT1) & ~expire & bus.s_ack_i;
    assign bus.m0_err_o = (state_q == GNT0) & (expire | bus.s_err_i);
    assign bus.m1_err_o = (state_q == GNT1) & (expire | bus.s_err_i);
    assign bus.m_dat_o  = bus.s_dat_i;

    assign grant_o = grant_q;

endmodule
